// File: rtl/serial_mag_comp_ctrl.sv
// serial_mag_comp_ctrl: bit-serial unsigned magnitude comparator.
// Two WIDTH-bit operands are latched on a start request and fed MSB-first
// through a single 1-bit comparator cell, one bit per clock. The walk stops
// at the first differing bit, or after the LSB when the operands are equal.
// The result is held on l_o/g_o/e_o and announced with a one-cycle done_o.

// 1-bit magnitude comparator cell: exactly one of L/G/E is high.
module mag_comp_1bit (
    input  logic a,
    input  logic b,
    output logic L,
    output logic G,
    output logic E
);
    assign L = ~a &  b;
    assign G =  a & ~b;
    assign E = ~(a ^ b);
endmodule

module serial_mag_comp_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             l_o,
    output logic             g_o,
    output logic             e_o
);
    // The bit counter needs at least one bit, even for WIDTH=1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             l_q;
    logic             g_q;
    logic             e_q;

    logic             cell_l;
    logic             cell_g;
    logic             cell_e;

    // The cell always looks at the current MSB of the shifting operands.
    mag_comp_1bit u_cell (
        .a (sa_q[WIDTH-1]),
        .b (sb_q[WIDTH-1]),
        .L (cell_l),
        .G (cell_g),
        .E (cell_e)
    );

    // Sequencer: accept operands, walk bits MSB-first, register the verdict.
    always_ff @(posedge clk_i) begin
        // NOTE: state and outputs use non-blocking assignments so every
        // branch below reads the values from before this edge.
        if (rst_i) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            l_q     <= 1'b0;
            g_q     <= 1'b0;
            e_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        sa_q    <= a_i;
                        sb_q    <= b_i;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end

                RUN: begin
                    if (cell_l) begin
                        l_q     <= 1'b1;
                        g_q     <= 1'b0;
                        e_q     <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (cell_g) begin
                        l_q     <= 1'b0;
                        g_q     <= 1'b1;
                        e_q     <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (cell_e && (cnt_q == LAST_BIT)) begin
                        // All bits matched, including the LSB.
                        l_q     <= 1'b0;
                        g_q     <= 1'b0;
                        e_q     <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        // Bits equal so far: bring the next bit to the MSB.
                        sa_q  <= sa_q << 1;
                        sb_q  <= sb_q << 1;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                DONE: begin
                    // done_o lasts exactly one cycle; start is ignored here.
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign l_o    = l_q;
    assign g_o    = g_q;
    assign e_o    = e_q;

endmodule

// File: tb/tb_serial_mag_comp_ctrl.sv
// Directed testbench for serial_mag_comp_ctrl with WIDTH=8.
// Expected busy lengths and results are hand-computed from the operands.

module tb_serial_mag_comp_ctrl;
    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             l;
    logic             g;
    logic             e;

    int checks = 0;
    int errors = 0;

    serial_mag_comp_ctrl #(.WIDTH(WIDTH)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .a_i     (a),
        .b_i     (b),
        .busy_o  (busy),
        .done_o  (done),
        .l_o     (l),
        .g_o     (g),
        .e_o     (e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Follow a compare from the cycle after the accepting edge until done.
    // Optionally re-asserts start with different operands mid-RUN.
    task automatic wait_result(input bit inject, output int busy_cnt,
                               output bit done_seen, output logic [2:0] lge_first);
        busy_cnt  = 0;
        done_seen = 1'b0;
        lge_first = 3'b000;
        for (int cyc = 0; cyc < 20 && !done_seen; cyc++) begin
            @(negedge clk);
            if (done) begin
                done_seen = 1'b1;
            end else if (busy) begin
                busy_cnt++;
                if (busy_cnt == 1) lge_first = {l, g, e};
                if (inject && busy_cnt == 2) begin
                    start = 1'b1;
                    a     = 8'hFF;
                    b     = 8'h00;
                end
                if (inject && busy_cnt == 4) start = 1'b0;
            end
        end
    endtask

    // Pulse start for one edge with the given operands, then follow the run.
    task automatic run_compare(input logic [7:0] av, input logic [7:0] bv, input bit inject,
                               output int busy_cnt, output bit done_seen,
                               output logic [2:0] lge_first);
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_result(inject, busy_cnt, done_seen, lge_first);
    endtask

    // After a done cycle, done must drop and busy stay low on the next cycle.
    task automatic check_pulse_end(input string tag);
        @(negedge clk);
        check({tag, "_done_drop"}, done, 1'b0);
        check({tag, "_busy_after"}, busy, 1'b0);
    endtask

    int         bc;
    bit         ds;
    logic [2:0] lf;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_lge", {l, g, e}, 3'b000);
        rst = 1'b0;

        // MSB differs: n=1, A > B.
        run_compare(8'hA5, 8'h25, 1'b0, bc, ds, lf);
        check("a5_done", ds, 1'b1);
        check("a5_busy_len", bc, 1);
        check("a5_lge", {l, g, e}, 3'b010);
        check_pulse_end("a5");

        // LSB differs: n=8, A < B.
        run_compare(8'h3C, 8'h3D, 1'b0, bc, ds, lf);
        check("3c_done", ds, 1'b1);
        check("3c_busy_len", bc, 8);
        check("3c_lge", {l, g, e}, 3'b100);
        check("3c_hold_prev", lf, 3'b010);
        check_pulse_end("3c");

        // Equal operands: n=8, E. Next compare is queued at the first IDLE cycle.
        run_compare(8'h5A, 8'h5A, 1'b0, bc, ds, lf);
        check("eq_done", ds, 1'b1);
        check("eq_busy_len", bc, 8);
        check("eq_lge", {l, g, e}, 3'b001);
        start = 1'b1;
        a     = 8'h5B;
        b     = 8'h5A;
        @(posedge clk);        // DONE -> IDLE, start ignored
        @(negedge clk);
        check("b2b_idle_busy", busy, 1'b0);
        check("b2b_idle_done", done, 1'b0);
        @(posedge clk);        // first IDLE edge accepts
        #1;
        start = 1'b0;
        wait_result(1'b0, bc, ds, lf);
        check("b2b_done", ds, 1'b1);
        check("b2b_busy_len", bc, 8);
        check("b2b_hold_e", lf, 3'b001);
        check("b2b_lge", {l, g, e}, 3'b010);
        check_pulse_end("b2b");

        // start during RUN must be ignored.
        run_compare(8'h10, 8'h11, 1'b1, bc, ds, lf);
        check("ign_done", ds, 1'b1);
        check("ign_busy_len", bc, 8);
        check("ign_lge", {l, g, e}, 3'b100);
        check_pulse_end("ign");
        repeat (3) begin
            @(negedge clk);
            check("ign_no_restart", busy, 1'b0);
        end

        // Reset on the 3rd RUN cycle discards the compare.
        @(negedge clk);
        start = 1'b1;
        a     = 8'h3C;
        b     = 8'h3D;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy_before", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_lge", {l, g, e}, 3'b000);
        ds = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) ds = 1'b1;
        end
        check("mid_no_done", ds, 1'b0);

        run_compare(8'h80, 8'h7F, 1'b0, bc, ds, lf);
        check("post_rst_done", ds, 1'b1);
        check("post_rst_busy_len", bc, 1);
        check("post_rst_lge", {l, g, e}, 3'b010);
        check_pulse_end("post_rst");

        // After reset, idle with start low: all outputs stay 0.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_outputs", {busy, done, l, g, e}, 5'b00000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
